// File: rtl/servo_sequencer.sv
// Timed motion-profile controller driving the pulso speed select:
// RUN at a latched speed, optional PAUSE, repeated a programmed number of times.
module servo_sequencer #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] run_sel,
    input  logic [3:0] run_time,
    input  logic [3:0] stop_time,
    input  logic [3:0] repeat_cnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [1:0] SEL_STOP = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    sec_q, sec_d;
    logic [3:0]    rep_q, rep_d;
    logic [1:0]    cfg_sel_q, cfg_sel_d;
    logic [3:0]    cfg_run_q, cfg_run_d;
    logic [3:0]    cfg_stop_q, cfg_stop_d;
    logic [3:0]    cfg_rep_q, cfg_rep_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick_wrap;
    logic [3:0]    sec_inc;
    logic [3:0]    rep_inc;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        sec_d      = sec_q;
        rep_d      = rep_q;
        cfg_sel_d  = cfg_sel_q;
        cfg_run_d  = cfg_run_q;
        cfg_stop_d = cfg_stop_q;
        cfg_rep_d  = cfg_rep_q;
        tick_wrap  = (tick_q == TICK_LAST);
        sec_inc    = sec_q + 4'd1;
        rep_inc    = rep_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cfg_sel_d  = run_sel;
                    cfg_run_d  = run_time;
                    cfg_stop_d = stop_time;
                    cfg_rep_d  = repeat_cnt;
                    tick_d     = '0;
                    sec_d      = 4'd0;
                    rep_d      = 4'd0;
                    state_d    = (run_time == 4'd0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!tick_wrap) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d = '0;
                    sec_d  = sec_inc;
                    if (sec_inc == cfg_run_q) begin
                        sec_d = 4'd0;
                        rep_d = rep_inc;
                        // repeat_cnt of 0 never matches, so the counter just wraps
                        if (cfg_rep_q != 4'd0 && rep_inc == cfg_rep_q) begin
                            state_d = FINISH;
                        end else if (cfg_stop_q == 4'd0) begin
                            state_d = RUN;
                        end else begin
                            state_d = PAUSE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!tick_wrap) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d = '0;
                    sec_d  = sec_inc;
                    if (sec_inc == cfg_stop_q) begin
                        sec_d   = 4'd0;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        sel_d  = (state_d == RUN) ? cfg_sel_d : SEL_STOP;
        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            sec_q      <= 4'd0;
            rep_q      <= 4'd0;
            cfg_sel_q  <= SEL_STOP;
            cfg_run_q  <= 4'd0;
            cfg_stop_q <= 4'd0;
            cfg_rep_q  <= 4'd0;
            sel_q      <= SEL_STOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            rep_q      <= rep_d;
            cfg_sel_q  <= cfg_sel_d;
            cfg_run_q  <= cfg_run_d;
            cfg_stop_q <= cfg_stop_d;
            cfg_rep_q  <= cfg_rep_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer with TICK_CYCLES=4; cycle n is the n-th
// clock after the edge that samples start, observed on the falling edge.
module tb_servo_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] run_sel = 2'd0;
    logic [3:0] run_time = 4'd0;
    logic [3:0] stop_time = 4'd0;
    logic [3:0] repeat_cnt = 4'd0;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    servo_sequencer #(.TICK_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .run_sel    (run_sel),
        .run_time   (run_time),
        .stop_time  (stop_time),
        .repeat_cnt (repeat_cnt),
        .sel        (sel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic configure(input logic [1:0] s, input logic [3:0] rt,
                             input logic [3:0] st, input logic [3:0] rc);
        run_sel    = s;
        run_time   = rt;
        stop_time  = st;
        repeat_cnt = rc;
    endtask

    task automatic test_reset();
        logic [1:0] sel_e;
        // power-on reset state
        checks++;
        if (sel !== 2'd3 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got sel=%0d busy=%0d done=%0d expected 3/0/0", sel, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        configure(2'd2, 4'd3, 4'd2, 4'd2);
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) start = 1'b0;
        end
        checks++;
        if (sel !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got sel=%0d busy=%0d expected 2/1", sel, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 2'd3 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got sel=%0d busy=%0d done=%0d expected 3/0/0", sel, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel_e = 2'd3;
        for (int n = 1; n <= 4; n++) begin
            step();
            checks++;
            if (sel !== sel_e || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got sel=%0d busy=%0d done=%0d expected 3/0/0", n, sel, busy, done);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [1:0] sel_e;
        logic       busy_e, done_e;
        configure(2'd2, 4'd3, 4'd2, 4'd2);
        start = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            step();
            if (n == 1) start = 1'b0;
            sel_e  = ((n >= 1 && n <= 12) || (n >= 21 && n <= 32)) ? 2'd2 : 2'd3;
            busy_e = (n <= 32);
            done_e = (n == 33);
            checks++;
            if (sel !== sel_e || busy !== busy_e || done !== done_e) begin
                errors++;
                $display("FAIL basic cycle %0d: got sel=%0d busy=%0d done=%0d expected %0d/%0d/%0d",
                         n, sel, busy, done, sel_e, busy_e, done_e);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_back_to_back();
        logic [1:0] sel_e;
        logic       busy_e, done_e;
        configure(2'd1, 4'd1, 4'd0, 4'd3);
        start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            if (n == 1) start = 1'b0;
            sel_e  = (n <= 12) ? 2'd1 : 2'd3;
            busy_e = (n <= 12);
            done_e = (n == 13);
            checks++;
            if (sel !== sel_e || busy !== busy_e || done !== done_e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got sel=%0d busy=%0d done=%0d expected %0d/%0d/%0d",
                         n, sel, busy, done, sel_e, busy_e, done_e);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_infinite_abort();
        logic [1:0] sel_e;
        logic       busy_e;
        configure(2'd0, 4'd1, 4'd1, 4'd0);
        start = 1'b1;
        for (int n = 1; n <= 56; n++) begin
            step();
            if (n == 1) start = 1'b0;
            if (n <= 50) begin
                sel_e  = ((((n - 1) / 4) % 2) == 0) ? 2'd0 : 2'd3;
                busy_e = 1'b1;
            end else begin
                sel_e  = 2'd3;
                busy_e = 1'b0;
            end
            checks++;
            if (sel !== sel_e || busy !== busy_e || done !== 1'b0) begin
                errors++;
                $display("FAIL infinite_abort cycle %0d: got sel=%0d busy=%0d done=%0d expected %0d/%0d/0",
                         n, sel, busy, done, sel_e, busy_e);
            end
            if (n == 50) abort = 1'b1;
            if (n == 51) abort = 1'b0;
        end
        $display("test_infinite_abort done");
    endtask

    task automatic test_zero_run();
        logic done_e;
        configure(2'd1, 4'd0, 4'd2, 4'd1);
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) start = 1'b0;
            done_e = (n == 1);
            checks++;
            if (sel !== 2'd3 || busy !== 1'b0 || done !== done_e) begin
                errors++;
                $display("FAIL zero_run cycle %0d: got sel=%0d busy=%0d done=%0d expected 3/0/%0d",
                         n, sel, busy, done, done_e);
            end
        end
        $display("test_zero_run done");
    endtask

    task automatic test_ignored_inputs();
        logic [1:0] sel_e;
        logic       busy_e, done_e;
        configure(2'd2, 4'd3, 4'd2, 4'd2);
        start = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            step();
            if (n == 1) start = 1'b0;
            sel_e  = ((n >= 1 && n <= 12) || (n >= 21 && n <= 32)) ? 2'd2 : 2'd3;
            busy_e = (n <= 32);
            done_e = (n == 33);
            checks++;
            if (sel !== sel_e || busy !== busy_e || done !== done_e) begin
                errors++;
                $display("FAIL ignored cycle %0d: got sel=%0d busy=%0d done=%0d expected %0d/%0d/%0d",
                         n, sel, busy, done, sel_e, busy_e, done_e);
            end
            if (n == 5 || n == 16) begin
                start = 1'b1;
                configure(2'd1, 4'd7, 4'd5, 4'd1);
            end
            if (n == 6 || n == 17) start = 1'b0;
        end
        // start together with abort in IDLE must not launch a profile
        configure(2'd1, 4'd2, 4'd1, 4'd1);
        start = 1'b1;
        abort = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            checks++;
            if (sel !== 2'd3 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_abort cycle %0d: got sel=%0d busy=%0d done=%0d expected 3/0/0",
                         n, sel, busy, done);
            end
        end
        $display("test_ignored_inputs done");
    endtask

    initial begin
        #12;
        test_reset();
        test_basic();
        test_back_to_back();
        test_infinite_abort();
        test_zero_run();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_sequencer.md
# servo_sequencer

Timed motion-profile controller for the servo PWM generator (`pulso`). It drives the generator's 2-bit speed select through a programmed profile: hold a speed for a number of seconds, stop for a number of seconds, and repeat a set number of times. It replaces hard-wired per-test sequencing logic with one reusable block. The block sits between the board clock and the `pulso` instance, and its `sel` output feeds `pulso.sel` directly.

## Interface
- `TICK_CYCLES`, default 50_000_000: `clk` cycles per profile second (1 s at 50 MHz); the bench uses 4.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request to start a profile; sampled only in IDLE.
- `abort` input, 1 bit: stop immediately; effective in any state.
- `run_sel` input, 2 bits: speed select applied during RUN (3 is legal and gives constant 0).
- `run_time` input, 4 bits: RUN length in seconds, 0..15.
- `stop_time` input, 4 bits: PAUSE length in seconds, 0..15.
- `repeat_cnt` input, 4 bits: number of RUN phases; 0 means repeat until `abort`.
- `sel` output, 2 bits: select to `pulso`; registered.
- `busy` output, 1 bit: high in RUN and PAUSE.
- `done` output, 1 bit: one-cycle pulse when a profile completes normally.

## Operation
- States are IDLE, RUN, PAUSE and FINISH. `sel` is 3 (constant 0) in every state except RUN.
- **Reset (async):** state = IDLE, `sel` = 3, `busy` = 0, `done` = 0, all counters = 0.
- **IDLE:** `start`=1 and `abort`=0 latches `run_sel`, `run_time`, `stop_time` and `repeat_cnt`.
  - If the latched `run_time` is 0, go to FINISH.
  - Otherwise go to RUN and clear the tick, second and repeat counters.
  - Input changes after this latch have no effect until the next IDLE.
- **RUN:** `sel` = latched `run_sel`. The tick counter counts 0..TICK_CYCLES-1; on wrap the second counter increments.
  - When the second counter reaches `run_time`, the RUN ends and the repeat counter increments.
  - If the repeat counter now equals a nonzero `repeat_cnt`, go to FINISH.
  - Else, if `stop_time` is 0, start a new RUN directly with counters cleared and `sel` unchanged.
  - Otherwise go to PAUSE.
- **PAUSE:** `sel` = 3. Tick and second counting is the same as in RUN. When the second counter reaches `stop_time`, go to RUN with counters cleared.
  - No PAUSE follows the final RUN.
- **FINISH:** lasts one cycle: `done` = 1, `busy` = 0, `sel` = 3. Then go to IDLE. `start` is ignored in FINISH.
- **abort=1:** in RUN or PAUSE, go to IDLE on the next edge: `sel` = 3, `busy` = 0, no `done`. In IDLE, `abort` beats `start`.
- `start` in RUN or PAUSE is ignored; the profile does not restart.
- **Widths:** the tick counter is $clog2(TICK_CYCLES) bits. The second and repeat counters are 4 bits. With `repeat_cnt` = 0 the repeat counter wraps 15→0 without effect.

## Timing
- `start` sampled high at edge k gives `sel` = `run_sel` and `busy` = 1 from edge k+1 (1-cycle latency).
- RUN lasts exactly `run_time` × TICK_CYCLES cycles. PAUSE lasts exactly `stop_time` × TICK_CYCLES cycles.
- A back-to-back RUN (`stop_time` = 0) keeps `sel` constant with no glitch cycle.
- `done` is high in the single cycle after the final RUN cycle, and IDLE follows on the next edge. A new `start` is accepted from that IDLE cycle.
- With `run_time` = 0, `done` is high at edge k+1 and `busy` never rises.
- `abort` sampled at edge k gives `sel` = 3 at edge k+1.
- Reset asserted mid-profile forces the reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with no clock edge → `sel`=3, `busy`=0, `done`=0 immediately; after release, state stays IDLE until `start`.
- **Basic profile:** TICK_CYCLES=4, `run_sel`=2, `run_time`=3, `stop_time`=2, `repeat_cnt`=2, `start` at cycle 0 →
  - `sel`=2 on cycles 1–12, 3 on cycles 13–20, 2 on cycles 21–32;
  - `done`=1 only on cycle 33, `busy`=0 from cycle 33.
- **Back-to-back runs:** `run_time`=1, `stop_time`=0, `repeat_cnt`=3, `run_sel`=1 → `sel`=1 continuously on cycles 1–12, `done` on cycle 13.
- **Infinite profile with abort:** `repeat_cnt`=0; `abort` pulsed at cycle 50 → `sel`=3 and `busy`=0 at cycle 51, `done` never asserted.
- **Zero run time:** `run_time`=0 → `done` on cycle 1, `sel` stays 3, `busy` stays 0.
- **Ignored inputs while busy:** re-pulse `start` and change all config inputs mid-RUN → profile timing is identical to the basic-profile case. `start` and `abort` together in IDLE → stays IDLE.
